fetch_queue: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter and upstream of decode. Owns the fetch PC, issues word reads to a synchronous instruction memory, and buffers returned {pc, instruction} pairs in a DEPTH-entry FIFO presented to decode with a valid/ready handshake. A branch/jump redirect flushes all buffered and in-flight fetches and restarts fetching at the new target.

---
 rtl/fetch_queue.sv | 111 +++++++++++
 tb/tb_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to a synchronous
// instruction memory and buffers {pc, instr} pairs in a FIFO toward decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [CW-1:0] count
);

  // Handshake: an entry moves to decode on a cycle where out_valid && out_ready;
  // out_valid never depends on out_ready, and a redirect suppresses both.

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [CW:0]   credit_used;
  logic          push;
  logic          pop;

  // Credit counts the in-flight read so a returning word always has a slot.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = rst_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;

  assign out_valid   = rst_n && !redirect_valid && (count_q != '0);
  assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign count       = count_q;

  assign push = inflight_q && !redirect_valid;
  assign pop  = out_valid && out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        req_pc_d   = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q   <= 32'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// plus directed literal expectations at hand-computed cycles.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int checks;
  int failures;
  int cyc;

  fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC),
    .PC_STEP(32'd1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .count(count)
  );

  // Clock and a synchronous instruction memory whose word is addr ^ KEY.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial imem_rdata = 32'h0;
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ KEY;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the FIFO is a queue of expected pcs (instr = pc ^ KEY).
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_inflight;

  initial begin
    logic        e_req;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        s_rv;
    logic        s_rdy;
    logic [31:0] s_rpc;
    m_pc       = RESET_PC;
    m_req_pc   = 32'h0;
    m_inflight = 1'b0;
    exp_q.delete();
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        m_pc       = RESET_PC;
        m_inflight = 1'b0;
        exp_q.delete();
      end
      e_req   = rst_n && !redirect_valid && ((exp_q.size() + int'(m_inflight)) < DEPTH);
      e_ov    = rst_n && !redirect_valid && (exp_q.size() != 0);
      e_pc    = e_ov ? exp_q[0] : 32'h0;
      e_instr = e_ov ? (exp_q[0] ^ KEY) : 32'h0;
      chk("m_imem_req", 32'(imem_req), 32'(e_req));
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_out_valid", 32'(out_valid), 32'(e_ov));
      chk("m_out_pc", out_pc, e_pc);
      chk("m_out_instr", out_instr, e_instr);
      chk("m_count", 32'(count), 32'(exp_q.size()));
      chk("m_count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
      s_rv  = redirect_valid;
      s_rpc = redirect_pc;
      s_rdy = out_ready;
      @(posedge clk);
      if (!rst_n) begin
        m_pc       = RESET_PC;
        m_inflight = 1'b0;
        exp_q.delete();
      end else if (s_rv) begin
        exp_q.delete();
        m_pc       = s_rpc;
        m_inflight = 1'b0;
      end else begin
        if (e_ov && s_rdy) void'(exp_q.pop_front());
        if (m_inflight) exp_q.push_back(m_req_pc);
        if (e_req) begin
          m_req_pc   = m_pc;
          m_pc       = m_pc + 32'd1;
          m_inflight = 1'b1;
        end else begin
          m_inflight = 1'b0;
        end
      end
    end
  end

  // Driver tasks: cycle N is the clock period ending at the N-th rising edge
  // after reset release; inputs change on the falling edge before it.
  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic reset_release(input logic rdy);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    // Streaming with out_ready=1, then a redirect and a PC wrap.
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    #2;
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    to_cycle(1); #2 chk("c1_valid", 32'(out_valid), 32'd0);
    to_cycle(2); #2;
    chk("c2_valid", 32'(out_valid), 32'd1);
    chk("c2_pc", out_pc, 32'h0);
    chk("c2_instr", out_instr, 32'hA5A5_0000);
    to_cycle(3); #2;
    chk("c3_pc", out_pc, 32'h1);
    chk("c3_count", 32'(count), 32'd1);
    to_cycle(5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #2 chk("r5_valid", 32'(out_valid), 32'd0);
    to_cycle(6);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;
    chk("r6_count", 32'(count), 32'd0);
    chk("r6_valid", 32'(out_valid), 32'd0);
    chk("r6_addr", imem_addr, 32'h0000_0100);
    to_cycle(7); #2 chk("r7_valid", 32'(out_valid), 32'd0);
    to_cycle(8); #2;
    chk("r8_pc", out_pc, 32'h0000_0100);
    chk("r8_instr", out_instr, 32'hA5A5_0100);
    to_cycle(9); #2 chk("r9_pc", out_pc, 32'h0000_0101);
    to_cycle(12);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    to_cycle(13);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    to_cycle(15); #2 chk("w15_pc", out_pc, 32'hFFFF_FFFE);
    to_cycle(16); #2 chk("w16_pc", out_pc, 32'hFFFF_FFFF);
    to_cycle(17); #2;
    chk("w17_pc", out_pc, 32'h0000_0000);
    chk("w17_instr", out_instr, 32'hA5A5_0000);
    to_cycle(18); #2 chk("w18_pc", out_pc, 32'h0000_0001);
    to_cycle(22);

    // Backpressure from cycle 0: fill to DEPTH, stall, then drain in order.
    reset_release(1'b0);
    to_cycle(3); #2 chk("b3_req", 32'(imem_req), 32'd1);
    to_cycle(4); #2;
    chk("b4_count", 32'(count), 32'd3);
    chk("b4_req", 32'(imem_req), 32'd0);
    to_cycle(5); #2 chk("b5_count", 32'(count), 32'd4);
    to_cycle(7); #2;
    chk("b7_count", 32'(count), 32'd4);
    chk("b7_req", 32'(imem_req), 32'd0);
    to_cycle(8);
    out_ready = 1'b1;
    #2 chk("b8_pc", out_pc, 32'h0);
    to_cycle(9); #2 chk("b9_pc", out_pc, 32'h1);
    to_cycle(12); #2 chk("b12_pc", out_pc, 32'h4);
    to_cycle(20);

    // Random out_ready with occasional redirects; the model checks every cycle.
    for (int i = 0; i < 300; i++) begin
      to_cycle(cyc + 1);
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom_range(0, 32'h0000_FFFF);
      end else begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
      end
    end
    to_cycle(cyc + 1);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Asynchronous reset mid-stream with three entries buffered.
    reset_release(1'b0);
    to_cycle(4); #2 chk("a4_count", 32'(count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("a_valid", 32'(out_valid), 32'd0);
    chk("a_count", 32'(count), 32'd0);
    chk("a_req", 32'(imem_req), 32'd0);
    chk("a_instr", out_instr, 32'h0);
    chk("a_addr", imem_addr, RESET_PC);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    #2 chk("a0_addr", imem_addr, RESET_PC);
    to_cycle(1); #2 chk("a1_valid", 32'(out_valid), 32'd0);
    to_cycle(2); #2;
    chk("a2_valid", 32'(out_valid), 32'd1);
    chk("a2_pc", out_pc, 32'h0);
    to_cycle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
